// File: rtl/pixel_mem_pkg.sv
// Shared types and constants for the Sobel pixel memory responder.
// Carries the arbitration FSM encoding, default widths and image geometry.
package pixel_mem_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        LOAD  = 2'd1,
        DUMP  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_STAT_W = 20;

    localparam int IMG_W   = 256;
    localparam int IMG_PIX = 65536;

endpackage

// File: rtl/pixel_mem_ram.sv
// Single-port byte RAM: write at the edge, registered read valid one cycle later.
// No backpressure; rdata holds until the next read strobe.
module pixel_mem_ram #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    input  logic              re,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/pixel_mem_responder.sv
// Avalon-MM pixel memory for the Sobel master plus host LOAD/DUMP streaming; master reads latency 1.
// LOAD is accepted 1 byte/cycle; DUMP uses a 2-entry output queue and stalls cleanly on dp_ready.
module pixel_mem_responder
    import pixel_mem_pkg::*;
#(
    parameter int          ADDR_W = DEF_ADDR_W,
    parameter logic [31:0] BASE   = 32'h0,
    parameter int          STAT_W = DEF_STAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addressBUS,
    input  logic              readEn,
    input  logic              writeEn,
    input  logic [7:0]        writeBUS,
    output logic [7:0]        readBus,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    input  logic              dp_start,
    output logic              dp_valid,
    output logic [7:0]        dp_data,
    input  logic              dp_ready,
    output logic              busy,
    output logic              err_range,
    output logic              err_busy,
    output logic [STAT_W-1:0] rd_cnt,
    output logic [STAT_W-1:0] wr_cnt
);

    state_t state, state_nx;

    logic [31:0]       off;
    logic              hit, serve, m_rd, m_wr, m_miss, start_ok;
    logic              ld_fire, dp_pop, dp_issue;
    logic [1:0]        occ;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining, iss_rem;

    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata, ram_rdata;

    logic              rd_pending;
    logic [7:0]        rd_hold;
    logic              inflight, sk_vld, h_vld_nx, s_vld_nx;
    logic [7:0]        sk_dat, h_dat_nx, s_dat_nx;

    assign off      = addressBUS - BASE;
    assign hit      = (off[31:ADDR_W] == '0);
    assign serve    = (state == SERVE);
    assign m_wr     = serve & writeEn & hit;
    assign m_rd     = serve & readEn & ~writeEn & hit;
    assign m_miss   = serve & (readEn | writeEn) & ~hit;
    assign start_ok = (ld_len != '0);
    assign ld_fire  = (state == LOAD) & ld_valid;
    assign dp_pop   = dp_valid & dp_ready;

    // Issue only if the byte will find a free slot when it lands next cycle.
    assign occ      = {1'b0, dp_valid} + {1'b0, sk_vld} + {1'b0, inflight};
    assign dp_issue = (state == DUMP) & (iss_rem != '0) & ((occ - {1'b0, dp_pop}) <= 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SERVE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            SERVE: begin
                if (ld_start) begin
                    if (start_ok) state_nx = LOAD;
                end else if (dp_start && start_ok) begin
                    state_nx = DUMP;
                end
            end
            LOAD:    if (ld_fire && remaining == (ADDR_W+1)'(1)) state_nx = SERVE;
            DUMP:    if (dp_pop && remaining == (ADDR_W+1)'(1)) state_nx = SERVE;
            default: state_nx = SERVE;
        endcase
    end

    always_comb begin
        busy      = (state != SERVE);
        ld_ready  = (state == LOAD);
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = off[ADDR_W-1:0];
        ram_wdata = writeBUS;
        unique case (state)
            SERVE: begin
                ram_we = m_wr;
                ram_re = m_rd;
            end
            LOAD: begin
                ram_we    = ld_valid;
                ram_addr  = ptr;
                ram_wdata = ld_data;
            end
            DUMP: begin
                ram_re   = dp_issue;
                ram_addr = ptr;
            end
            default: ;
        endcase
        // The byte presented on the reset edge must not reach memory.
        if (rst) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    pixel_mem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            remaining <= '0;
            iss_rem   <= '0;
        end else if (serve) begin
            if (ld_start || dp_start) begin
                ptr       <= ld_base;
                remaining <= ld_len;
                iss_rem   <= ld_len;
            end
        end else if (ld_fire) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
        end else if (state == DUMP) begin
            if (dp_issue) begin
                ptr     <= ptr + 1'b1;
                iss_rem <= iss_rem - 1'b1;
            end
            if (dp_pop) begin
                remaining <= remaining - 1'b1;
            end
        end
    end

    // readBus shows RAM data the cycle after a served read, then a latched copy.
    assign readBus = rd_pending ? ram_rdata : rd_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending <= 1'b0;
            rd_hold    <= '0;
            err_range  <= 1'b0;
            err_busy   <= 1'b0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
        end else begin
            rd_pending <= m_rd;
            if (m_miss && readEn && !writeEn) begin
                rd_hold <= '0;
            end else if (rd_pending) begin
                rd_hold <= ram_rdata;
            end
            if (m_miss) err_range <= 1'b1;
            if (!serve && (readEn || writeEn)) err_busy <= 1'b1;
            if (m_rd && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
            if (m_wr && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
        end
    end

    always_comb begin
        h_vld_nx = dp_valid;
        h_dat_nx = dp_data;
        s_vld_nx = sk_vld;
        s_dat_nx = sk_dat;
        if (dp_pop) begin
            h_vld_nx = sk_vld;
            h_dat_nx = sk_dat;
            s_vld_nx = 1'b0;
        end
        if (inflight) begin
            if (!h_vld_nx) begin
                h_vld_nx = 1'b1;
                h_dat_nx = ram_rdata;
            end else begin
                s_vld_nx = 1'b1;
                s_dat_nx = ram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            dp_valid <= 1'b0;
            dp_data  <= '0;
            sk_vld   <= 1'b0;
            sk_dat   <= '0;
        end else begin
            inflight <= dp_issue;
            dp_valid <= h_vld_nx;
            dp_data  <= h_dat_nx;
            sk_vld   <= s_vld_nx;
            sk_dat   <= s_dat_nx;
        end
    end

endmodule

// File: tb/tb_pixel_mem_responder.sv
// Scoreboard bench for pixel_mem_responder: expected master read data and dump bytes are queued
// by the stimulus and consumed by a monitor on the falling edge.
module tb_pixel_mem_responder;

    localparam int          AW   = 16;
    localparam int          SW   = 20;
    localparam logic [31:0] BASE = 32'h1000;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   addressBUS;
    logic          readEn, writeEn;
    logic [7:0]    writeBUS, readBus;
    logic          ld_start, ld_valid, ld_ready;
    logic [AW-1:0] ld_base;
    logic [AW:0]   ld_len;
    logic [7:0]    ld_data;
    logic          dp_start, dp_valid, dp_ready;
    logic [7:0]    dp_data;
    logic          busy, err_range, err_busy;
    logic [SW-1:0] rd_cnt, wr_cnt;

    pixel_mem_responder #(.ADDR_W(AW), .BASE(BASE), .STAT_W(SW)) dut (
        .clk(clk), .rst(rst), .addressBUS(addressBUS), .readEn(readEn), .writeEn(writeEn),
        .writeBUS(writeBUS), .readBus(readBus), .ld_start(ld_start), .ld_base(ld_base),
        .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .dp_start(dp_start), .dp_valid(dp_valid), .dp_data(dp_data), .dp_ready(dp_ready),
        .busy(busy), .err_range(err_range), .err_busy(err_busy), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] rd_q[$];
    logic [7:0] dp_q[$];
    logic       rd_expect = 1'b0;
    logic       rd_fire = 1'b0;
    logic       stall_flag = 1'b0;
    logic [7:0] stall_dat = 8'h00;

    logic [7:0] load_a[4]  = '{8'h10, 8'h20, 8'h30, 8'h40};
    logic [7:0] wrap_b[4]  = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic       rdy_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_fire <= rd_expect;

    always @(negedge clk) begin
        if (rd_fire) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got 0x%0h with no read expected", readBus);
            end else begin
                check("rd_data", {24'h0, readBus}, {24'h0, rd_q.pop_front()});
            end
        end
        if (stall_flag) begin
            check("dp_stall_vld", {31'h0, dp_valid}, 32'h1);
            check("dp_stall_dat", {24'h0, dp_data}, {24'h0, stall_dat});
        end
        stall_flag = dp_valid && !dp_ready;
        stall_dat  = dp_data;
        if (dp_valid && dp_ready) begin
            if (dp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dp_extra: got byte 0x%0h beyond the requested length", dp_data);
            end else begin
                check("dp_data", {24'h0, dp_data}, {24'h0, dp_q.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mrd(input logic [31:0] a, input logic [7:0] e);
        addressBUS = a;
        readEn     = 1'b1;
        rd_expect  = 1'b1;
        rd_q.push_back(e);
        cyc();
        readEn    = 1'b0;
        rd_expect = 1'b0;
    endtask

    task automatic mwr(input logic [31:0] a, input logic [7:0] d);
        addressBUS = a;
        writeBUS   = d;
        writeEn    = 1'b1;
        cyc();
        writeEn = 1'b0;
    endtask

    task automatic start(input logic is_load, input logic [AW-1:0] b, input logic [AW:0] n);
        ld_base  = b;
        ld_len   = n;
        ld_start = is_load;
        dp_start = !is_load;
        cyc();
        ld_start = 1'b0;
        dp_start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; addressBUS = '0; readEn = 0; writeEn = 0; writeBUS = '0;
        ld_start = 0; ld_base = '0; ld_len = '0; ld_valid = 0; ld_data = '0;
        dp_start = 0; dp_ready = 0;
        cyc(); cyc();
        rst = 1'b0;
        check("rst_readBus", {24'h0, readBus}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
        check("rst_dp_valid", {31'h0, dp_valid}, 32'h0);
        check("rst_err", {30'h0, err_range, err_busy}, 32'h0);
        check("rst_cnt", {12'h0, rd_cnt}, 32'h0);

        // LOAD four bytes with gaps, then read one back.
        start(1'b1, 16'h0100, 17'd4);
        check("load_busy", {31'h0, busy}, 32'h1);
        check("load_ready", {31'h0, ld_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            ld_data  = load_a[i];
            ld_valid = 1'b1;
            cyc();
            ld_valid = 1'b0;
            if (i < 3) check("load_busy_mid", {31'h0, busy}, 32'h1);
            if (i % 2 == 0) cyc();
        end
        check("load_done_busy", {31'h0, busy}, 32'h0);
        check("load_done_ready", {31'h0, ld_ready}, 32'h0);
        mrd(BASE + 32'h0102, 8'h30);
        cyc(); cyc();
        check("rd_hold", {24'h0, readBus}, 32'h30);
        check("rd_cnt_1", {12'h0, rd_cnt}, 32'd1);

        // Write, read back, then simultaneous read+write.
        mwr(BASE + 32'h5, 8'hFF);
        mrd(BASE + 32'h5, 8'hFF);
        addressBUS = BASE + 32'h6; writeBUS = 8'hAA; readEn = 1'b1; writeEn = 1'b1;
        cyc();
        readEn = 1'b0; writeEn = 1'b0;
        cyc();
        check("rdwr_readBus", {24'h0, readBus}, 32'hFF);
        check("rdwr_wr_cnt", {12'h0, wr_cnt}, 32'd2);
        check("rdwr_rd_cnt", {12'h0, rd_cnt}, 32'd2);
        mrd(BASE + 32'h6, 8'hAA);
        cyc();
        check("rd_cnt_3", {12'h0, rd_cnt}, 32'd3);

        // Window misses below and above the memory.
        check("err_range_clear", {31'h0, err_range}, 32'h0);
        mrd(32'h0000_0FFF, 8'h00);
        cyc();
        check("miss_rd_err", {31'h0, err_range}, 32'h1);
        check("miss_rd_cnt", {12'h0, rd_cnt}, 32'd3);
        mwr(BASE, 8'h77);
        mwr(32'h0001_1000, 8'h55);
        cyc();
        check("miss_wr_err", {31'h0, err_range}, 32'h1);
        check("miss_wr_cnt", {12'h0, wr_cnt}, 32'd3);
        mrd(BASE, 8'h77);

        // Wrapping preload at 0xFFFE, then a stalled DUMP with a master read during it.
        start(1'b1, 16'hFFFE, 17'd4);
        for (int i = 0; i < 4; i++) begin
            ld_data  = wrap_b[i];
            ld_valid = 1'b1;
            cyc();
        end
        ld_valid = 1'b0;
        check("wrap_load_done", {31'h0, busy}, 32'h0);
        mrd(BASE + 32'h1, 8'h04);
        mrd(BASE + 32'hFFFF, 8'h02);
        cyc();
        for (int i = 0; i < 4; i++) dp_q.push_back(wrap_b[i]);
        start(1'b0, 16'hFFFE, 17'd4);
        check("dump_busy", {31'h0, busy}, 32'h1);
        for (int i = 0; i < 7; i++) begin
            dp_ready = rdy_pat[i];
            if (i == 2) begin
                addressBUS = BASE + 32'h5;
                readEn     = 1'b1;
            end
            cyc();
            readEn = 1'b0;
        end
        dp_ready = 1'b1;
        for (int t = 0; t < 40 && busy; t++) cyc();
        check("dump_done", {31'h0, busy}, 32'h0);
        check("dump_all_out", dp_q.size(), 32'd0);
        check("dump_err_busy", {31'h0, err_busy}, 32'h1);
        check("dump_readBus", {24'h0, readBus}, 32'h02);
        check("dump_rd_cnt", {12'h0, rd_cnt}, 32'd6);

        // Full-rate DUMP: 4 bytes take 6 cycles from entering DUMP.
        for (int i = 0; i < 4; i++) dp_q.push_back(wrap_b[i]);
        start(1'b0, 16'hFFFE, 17'd4);
        begin
            int n;
            n = 0;
            while (busy && n < 40) begin
                cyc();
                n++;
            end
            check("dump_cycles", n, 32'd6);
        end
        check("dump2_all_out", dp_q.size(), 32'd0);
        dp_ready = 1'b0;

        // Reset on the 3rd byte of a 6-byte LOAD.
        mwr(BASE + 32'h0202, 8'h5A);
        start(1'b1, 16'h0200, 17'd6);
        ld_valid = 1'b1;
        ld_data = 8'hA1; cyc();
        ld_data = 8'hA2; cyc();
        ld_data = 8'hA3; rst = 1'b1; cyc();
        rst = 1'b0; ld_valid = 1'b0;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_ready", {31'h0, ld_ready}, 32'h0);
        check("mid_rst_dp", {23'h0, dp_valid, dp_data}, 32'h0);
        check("mid_rst_readBus", {24'h0, readBus}, 32'h0);
        check("mid_rst_err", {30'h0, err_range, err_busy}, 32'h0);
        check("mid_rst_cnt", {rd_cnt[15:0], wr_cnt[15:0]}, 32'h0);
        mrd(BASE + 32'h0200, 8'hA1);
        mrd(BASE + 32'h0201, 8'hA2);
        mrd(BASE + 32'h0202, 8'h5A);
        cyc(); cyc();
        check("post_rst_rd_cnt", {12'h0, rd_cnt}, 32'd3);
        check("rd_all_seen", rd_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
